// File: rtl/cpu_pkg.sv
// Shared CPU constants and the write-buffer entry layout.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// In-order entry storage for the data write buffer: entries, per-entry valid
// bits, read/write pointers and occupancy count. The caller guarantees that
// push is never asserted when full and pop is never asserted when empty.
module wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  wb_entry_t                    push_entry,
    output wb_entry_t                    head,
    output logic [DEPTH-1:0]             valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
    output logic [CNT_W-1:0]             count
);

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry payload storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    // Pointers, valid bits and count; full/empty are judged from count only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = entries[rd_ptr];

    // Expose every stored address so the top level can run hazard compares.
    always_comb begin
        entry_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = entries[i].addr;
        end
    end

endmodule

// File: rtl/data_write_buffer.sv
// Data write buffer: accepts ALU results over valid/ready, drains them in order
// into the data memory write port and flags read-after-write hazards against
// the two operand read addresses.
module data_write_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    input  logic [ADDR_W-1:0] chk_addr_a,
    input  logic [ADDR_W-1:0] chk_addr_b,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic                         push;
    logic                         pop;
    wb_entry_t                    push_entry;
    wb_entry_t                    head;
    logic [DEPTH-1:0]             valid;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;

    // Ready depends on registered count only, so a pop never frees a slot for
    // a push in the same cycle and there is no path from wr_ack to in_ready.
    assign in_ready   = (count != FULL_COUNT);
    assign empty      = (count == '0);
    assign wr_en      = !empty;
    assign push       = in_valid && in_ready;
    assign pop        = wr_en && wr_ack;
    assign push_entry = '{addr: in_addr, data: in_data};
    assign wr_addr    = head.addr;
    assign wr_data    = head.data;

    wb_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .head       (head),
        .valid      (valid),
        .entry_addr (entry_addr),
        .count      (count)
    );

    // Hazard compare over all valid entries; the head being popped still counts.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entry_addr[i] == chk_addr_a)) begin
                hazard_a = 1'b1;
            end
            if (valid[i] && (entry_addr[i] == chk_addr_b)) begin
                hazard_b = 1'b1;
            end
        end
    end

endmodule
